// File: rtl/result_checker_pkg.sv
// Shared types for the SRAM result checker: sweep FSM states and mismatch-log entry layout.
// The log entry widths follow the default DATA_W / ADDR_W of result_checker.
package result_checker_pkg;

    localparam int unsigned CHK_DATA_W = 8;
    localparam int unsigned CHK_ADDR_W = 18;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } chk_state_t;

    typedef struct packed {
        logic [CHK_ADDR_W-1:0] addr;
        logic [CHK_DATA_W-1:0] out;
        logic [CHK_DATA_W-1:0] gold;
    } chk_log_t;

endpackage

// File: rtl/result_checker_chk_tol_cmp.sv
// Compare stage: registers the issued bank/address, then selects the returned words and checks
// |out - gold| <= tol on the signed low DATA_W bits without wrap.
module chk_tol_cmp #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned NUM_BANKS  = 6,
    parameter int unsigned BANK_IDX_W = 3,
    parameter int unsigned ADDR_W     = 18
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        issue_valid,
    input  logic [BANK_IDX_W-1:0]       issue_bank,
    input  logic [ADDR_W-1:0]           issue_addr,
    input  logic [DATA_W-1:0]           tol,
    input  logic [NUM_BANKS*WORD_W-1:0] dut_rdata,
    input  logic [NUM_BANKS*WORD_W-1:0] gold_rdata,
    output logic                        cmp_valid,
    output logic                        cmp_fail,
    output logic [ADDR_W-1:0]           cmp_addr,
    output logic [DATA_W-1:0]           cmp_out,
    output logic [DATA_W-1:0]           cmp_gold
);

    logic                  valid_q, valid_d;
    logic [BANK_IDX_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     out_w, gold_w;
    logic [DATA_W:0]       diff, mag;
    logic                  unused_hi;

    always_comb begin
        valid_d = issue_valid & ~flush;
        bank_d  = issue_valid ? issue_bank : bank_q;
        addr_d  = issue_valid ? issue_addr : addr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            bank_q  <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        out_w  = '0;
        gold_w = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (bank_q == BANK_IDX_W'(b)) begin
                out_w  = dut_rdata[b*WORD_W +: DATA_W];
                gold_w = gold_rdata[b*WORD_W +: DATA_W];
            end
        end
    end

    // Sign-extend by one bit so the difference of two DATA_W signed values cannot wrap.
    always_comb begin
        diff     = {out_w[DATA_W-1], out_w} - {gold_w[DATA_W-1], gold_w};
        mag      = diff[DATA_W] ? (~diff + (DATA_W+1)'(1)) : diff;
        cmp_fail = mag > {1'b0, tol};
    end

    assign cmp_valid = valid_q & ~flush;
    assign cmp_addr  = addr_q;
    assign cmp_out   = out_w;
    assign cmp_gold  = gold_w;
    assign unused_hi = ^{dut_rdata, gold_rdata};

endmodule

// File: rtl/result_checker.sv
// Sweeps a word range of the banked output and golden SRAMs in lock-step, counts tolerance
// mismatches, records the first failing address and logs the first LOG_DEPTH failures.
module result_checker
    import result_checker_pkg::*;
#(
    parameter int unsigned  DATA_W     = CHK_DATA_W,
    parameter int unsigned  WORD_W     = 16,
    parameter int unsigned  BANK_WORDS = 32768,
    parameter int unsigned  NUM_BANKS  = 6,
    parameter int unsigned  ADDR_W     = $clog2(BANK_WORDS * NUM_BANKS),
    parameter int unsigned  LOG_DEPTH  = 16,
    parameter int unsigned  CNT_W      = 32,
    localparam int unsigned BANK_AW    = $clog2(BANK_WORDS),
    localparam int unsigned LOG_AW     = $clog2(LOG_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [ADDR_W-1:0]           word_begin,
    input  logic [ADDR_W:0]             word_end,
    input  logic [DATA_W-1:0]           tol,
    output logic [NUM_BANKS-1:0]        dut_cs,
    output logic [NUM_BANKS-1:0]        gold_cs,
    output logic [BANK_AW-1:0]          dut_addr,
    output logic [BANK_AW-1:0]          gold_addr,
    input  logic [NUM_BANKS*WORD_W-1:0] dut_rdata,
    input  logic [NUM_BANKS*WORD_W-1:0] gold_rdata,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_W-1:0]            err_cnt,
    output logic                        first_err_valid,
    output logic [ADDR_W-1:0]           first_err_addr,
    input  logic [LOG_AW-1:0]           log_idx,
    output logic [ADDR_W-1:0]           log_addr,
    output logic [DATA_W-1:0]           log_out,
    output logic [DATA_W-1:0]           log_gold,
    output logic [LOG_AW:0]             log_cnt,
    output logic                        log_ovf
);

    localparam int unsigned     BANK_IDX_W  = ADDR_W - BANK_AW;
    localparam logic [ADDR_W:0] TOTAL_WORDS = (ADDR_W+1)'(BANK_WORDS * NUM_BANKS);

    chk_state_t        state_q, state_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   end_q, end_d;
    logic [DATA_W-1:0] tol_q, tol_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              fev_q, fev_d;
    logic [ADDR_W-1:0] fea_q, fea_d;
    logic [LOG_AW:0]   log_cnt_q, log_cnt_d;
    logic              log_ovf_q, log_ovf_d;

    logic                  accept, issue, abort_hit, log_we;
    logic [ADDR_W:0]       addr_nxt;
    logic [BANK_IDX_W-1:0] bank;
    logic [NUM_BANKS-1:0]  cs;
    logic                  cmp_valid, cmp_fail;
    logic [ADDR_W-1:0]     cmp_addr;
    logic [DATA_W-1:0]     cmp_out, cmp_gold;
    chk_log_t              log_q [LOG_DEPTH];
    chk_log_t              wr_entry, rd_entry;
    logic                  rd_hit;

    assign bank     = addr_q[ADDR_W-1:BANK_AW];
    assign addr_nxt = {1'b0, addr_q} + (ADDR_W+1)'(1);

    always_comb begin
        state_d   = state_q;
        pend_d    = 1'b0;
        addr_d    = addr_q;
        end_d     = end_q;
        tol_d     = tol_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_cnt_d = err_cnt_q;
        fev_d     = fev_q;
        fea_d     = fea_q;
        log_cnt_d = log_cnt_q;
        log_ovf_d = log_ovf_q;
        issue     = 1'b0;
        abort_hit = 1'b0;
        log_we    = 1'b0;
        accept    = start && !pend_q && (state_q == StIdle || state_q == StDone);

        // Inputs are latched on the accept edge; the range decision is taken one edge later.
        unique case (state_q)
            StIdle, StDone: begin
                if (pend_q) begin
                    if (end_q <= {1'b0, addr_q}) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                        busy_d  = 1'b1;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_d   = StDone;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    issue  = 1'b1;
                    addr_d = addr_nxt[ADDR_W-1:0];
                    if (addr_nxt == end_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                abort_hit = abort;
                state_d   = StDone;
                busy_d    = 1'b0;
                done_d    = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (cmp_valid && cmp_fail) begin
            err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
            if (!fev_q) begin
                fev_d = 1'b1;
                fea_d = cmp_addr;
            end
            if (!log_cnt_q[LOG_AW]) begin
                log_we    = 1'b1;
                log_cnt_d = log_cnt_q + (LOG_AW+1)'(1);
            end else begin
                log_ovf_d = 1'b1;
            end
        end

        if (accept) begin
            pend_d    = 1'b1;
            addr_d    = word_begin;
            end_d     = (word_end > TOTAL_WORDS) ? TOTAL_WORDS : word_end;
            tol_d     = tol;
            done_d    = 1'b0;
            err_cnt_d = '0;
            fev_d     = 1'b0;
            fea_d     = '0;
            log_cnt_d = '0;
            log_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pend_q    <= 1'b0;
            addr_q    <= '0;
            end_q     <= '0;
            tol_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_cnt_q <= '0;
            fev_q     <= 1'b0;
            fea_q     <= '0;
            log_cnt_q <= '0;
            log_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            addr_q    <= addr_d;
            end_q     <= end_d;
            tol_q     <= tol_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_cnt_q <= err_cnt_d;
            fev_q     <= fev_d;
            fea_q     <= fea_d;
            log_cnt_q <= log_cnt_d;
            log_ovf_q <= log_ovf_d;
        end
    end

    always_comb begin
        cs = '0;
        if (state_q == StRun) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                cs[b] = (bank == BANK_IDX_W'(b));
            end
        end
    end

    chk_tol_cmp #(
        .DATA_W     (DATA_W),
        .WORD_W     (WORD_W),
        .NUM_BANKS  (NUM_BANKS),
        .BANK_IDX_W (BANK_IDX_W),
        .ADDR_W     (ADDR_W)
    ) u_cmp (
        .clk         (clk),
        .rst         (rst),
        .flush       (abort_hit),
        .issue_valid (issue),
        .issue_bank  (bank),
        .issue_addr  (addr_q),
        .tol         (tol_q),
        .dut_rdata   (dut_rdata),
        .gold_rdata  (gold_rdata),
        .cmp_valid   (cmp_valid),
        .cmp_fail    (cmp_fail),
        .cmp_addr    (cmp_addr),
        .cmp_out     (cmp_out),
        .cmp_gold    (cmp_gold)
    );

    assign wr_entry = '{addr: cmp_addr, out: cmp_out, gold: cmp_gold};

    always_ff @(posedge clk) begin
        if (log_we) begin
            log_q[log_cnt_q[LOG_AW-1:0]] <= wr_entry;
        end
    end

    // Entries beyond log_cnt read as zero so stale or uninitialised flops never leak out.
    always_comb begin
        rd_entry = log_q[log_idx];
        rd_hit   = {1'b0, log_idx} < log_cnt_q;
        log_addr = rd_hit ? rd_entry.addr : '0;
        log_out  = rd_hit ? rd_entry.out  : '0;
        log_gold = rd_hit ? rd_entry.gold : '0;
    end

    assign dut_cs          = cs;
    assign gold_cs         = cs;
    assign dut_addr        = addr_q[BANK_AW-1:0];
    assign gold_addr       = addr_q[BANK_AW-1:0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = fev_q;
    assign first_err_addr  = fea_q;
    assign log_cnt         = log_cnt_q;
    assign log_ovf         = log_ovf_q;

endmodule

// File: tb/tb_result_checker.sv
// Randomised scoreboard bench for result_checker: a word-level reference model predicts each
// sweep's result, and a monitor checks it when done rises.
module tb_result_checker;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned BANK_WORDS = 32768;
    localparam int unsigned NUM_BANKS  = 6;
    localparam int unsigned ADDR_W     = 18;
    localparam int unsigned LOG_DEPTH  = 16;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned BANK_AW    = 15;
    localparam int unsigned LOG_AW     = 4;
    localparam int          TOTAL      = BANK_WORDS * NUM_BANKS;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        start = 1'b0;
    logic                        abort = 1'b0;
    logic [ADDR_W-1:0]           word_begin = '0;
    logic [ADDR_W:0]             word_end = '0;
    logic [DATA_W-1:0]           tol = '0;
    logic [NUM_BANKS-1:0]        dut_cs, gold_cs;
    logic [BANK_AW-1:0]          dut_addr, gold_addr;
    logic [NUM_BANKS*WORD_W-1:0] dut_rdata = '0;
    logic [NUM_BANKS*WORD_W-1:0] gold_rdata = '0;
    logic                        busy, done, first_err_valid, log_ovf;
    logic [CNT_W-1:0]            err_cnt;
    logic [ADDR_W-1:0]           first_err_addr, log_addr;
    logic [LOG_AW-1:0]           log_idx = '0;
    logic [DATA_W-1:0]           log_out, log_gold;
    logic [LOG_AW:0]             log_cnt;

    result_checker dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .word_begin      (word_begin),
        .word_end        (word_end),
        .tol             (tol),
        .dut_cs          (dut_cs),
        .gold_cs         (gold_cs),
        .dut_addr        (dut_addr),
        .gold_addr       (gold_addr),
        .dut_rdata       (dut_rdata),
        .gold_rdata      (gold_rdata),
        .busy            (busy),
        .done            (done),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr),
        .log_idx         (log_idx),
        .log_addr        (log_addr),
        .log_out         (log_out),
        .log_gold        (log_gold),
        .log_cnt         (log_cnt),
        .log_ovf         (log_ovf)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WORD_W-1:0] dut_mem  [TOTAL];
    logic [WORD_W-1:0] gold_mem [TOTAL];

    always @(posedge clk) begin
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if (dut_cs[b]) dut_rdata[b*WORD_W +: WORD_W] <= dut_mem[b*BANK_WORDS + int'(dut_addr)];
            if (gold_cs[b]) gold_rdata[b*WORD_W +: WORD_W] <= gold_mem[b*BANK_WORDS + int'(gold_addr)];
        end
    end

    typedef struct packed {
        logic [31:0] err;
        logic        fev;
        logic [17:0] fea;
        logic [4:0]  lcnt;
        logic        ovf;
        logic [31:0] done_cyc;
        logic [31:0] busy_cyc;
    } exp_t;

    typedef struct packed {
        logic [17:0] a;
        logic [7:0]  o;
        logic [7:0]  g;
    } ent_t;

    typedef struct packed {
        logic [31:0] c;
        logic [5:0]  cs;
        logic [14:0] a;
    } tr_t;

    exp_t exp_q[$];
    ent_t elog_q[$];
    tr_t  trace_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_checked = 0;
    int   busy_rise = 0;
    int   cs_err = 0;
    bit   trace_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: signed word-by-word comparison over [b, stop).
    task automatic model(input int b, input int stop, input int t, input int dc, input int bc);
        exp_t ex;
        ex = '0;
        for (int a = b; a < stop; a++) begin
            int o, g, d;
            o = int'($signed(dut_mem[a][7:0]));
            g = int'($signed(gold_mem[a][7:0]));
            d = (o > g) ? o - g : g - o;
            if (d > t) begin
                if (ex.err == 0) begin
                    ex.fev = 1'b1;
                    ex.fea = 18'(a);
                end
                ex.err = ex.err + 32'd1;
                if (ex.lcnt < 5'd16) begin
                    elog_q.push_back({18'(a), dut_mem[a][7:0], gold_mem[a][7:0]});
                    ex.lcnt = ex.lcnt + 5'd1;
                end else begin
                    ex.ovf = 1'b1;
                end
            end
        end
        ex.done_cyc = 32'(dc);
        ex.busy_cyc = 32'(bc);
        exp_q.push_back(ex);
    endtask

    task automatic fill(input int b, input int e, input int spread);
        for (int a = b; a < e; a++) begin
            logic [15:0] r1, r2;
            int d;
            r1 = 16'($urandom);
            r2 = 16'($urandom);
            d = (spread == 0) ? 0 : int'($urandom_range(0, 2 * spread)) - spread;
            dut_mem[a] = r1;
            gold_mem[a] = {r2[15:8], 8'(int'(r1[7:0]) + d)};
        end
    endtask

    task automatic set_pair(input int a, input logic [7:0] o, input logic [7:0] g);
        dut_mem[a][7:0] = o;
        gold_mem[a][7:0] = g;
    endtask

    // Called at a negedge; edge 0 is the next posedge.
    task automatic run(input int b, input int e, input int t, input int abort_at);
        int ee, n, k, target, limit, dc, bc;
        ee = (e > TOTAL) ? TOTAL : e;
        n = (ee > b) ? ee - b : 0;
        k = cyc;
        limit = (abort_at > 0) ? abort_at - 3 : n;
        dc = (abort_at > 0) ? k + 1 + abort_at : ((n > 0) ? k + n + 3 : k + 2);
        bc = (n > 0) ? k + 2 : 0;
        model(b, b + ((limit < n) ? limit : n), t, dc, bc);
        target = n_checked + 1;
        busy_rise = 0;
        word_begin = ADDR_W'(b);
        word_end = (ADDR_W+1)'(e);
        tol = DATA_W'(t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        for (int i = 0; i < n + 200 && n_checked < target; i++) @(negedge clk);
        if (n_checked < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: range %0d..%0d never reported done", b, e);
            exp_q.delete();
            elog_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ctl"}, 64'({dut_cs, gold_cs, dut_addr, gold_addr, busy, done,
                                  first_err_valid, log_ovf, log_cnt}), 64'd0);
        check({tag, " cnt"}, 64'({err_cnt, first_err_addr}), 64'd0);
        check({tag, " log"}, 64'({log_addr, log_out, log_gold}), 64'd0);
    endtask

    // Monitor: protocol checks every cycle, scoreboard pop on each rising done.
    initial begin
        logic busy_prev, done_prev;
        exp_t ex;
        ent_t en;
        busy_prev = 1'b0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (dut_cs !== gold_cs || dut_addr !== gold_addr) cs_err++;
            if (!busy && dut_cs != '0) cs_err++;
            if ($countones(dut_cs) > 1) cs_err++;
            if (trace_en && dut_cs != '0) trace_q.push_back({32'(cyc), dut_cs, dut_addr});
            if (busy && !busy_prev) busy_rise = cyc;
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected done at cycle %0d", cyc);
                end else begin
                    ex = exp_q.pop_front();
                    check("err_cnt", 64'(err_cnt), 64'(ex.err));
                    check("first_err_valid", 64'(first_err_valid), 64'(ex.fev));
                    check("first_err_addr", 64'(first_err_addr), 64'(ex.fea));
                    check("log_cnt", 64'(log_cnt), 64'(ex.lcnt));
                    check("log_ovf", 64'(log_ovf), 64'(ex.ovf));
                    check("done edge", 64'(cyc), 64'(ex.done_cyc));
                    check("busy rise edge", 64'(busy_rise), 64'(ex.busy_cyc));
                    for (int i = 0; i < int'(ex.lcnt); i++) begin
                        log_idx = LOG_AW'(i);
                        #1;
                        en = elog_q.pop_front();
                        check("log entry", 64'({log_addr, log_out, log_gold}), 64'(en));
                    end
                end
                n_checked++;
            end
            busy_prev = busy;
            done_prev = done;
        end
    end

    initial begin
        #(100 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Clean 2000-word sweep.
        fill(0, 2000, 0);
        run(0, 2000, 1, 0);

        // One within tolerance, one outside.
        fill(0, 16, 0);
        set_pair(5, 8'h10, 8'h11);
        set_pair(7, 8'h10, 8'h12);
        run(0, 16, 1, 0);

        // Bank boundary with cs trace.
        fill(32766, 32770, 0);
        trace_q.delete();
        trace_en = 1'b1;
        run(32766, 32770, 0, 0);
        trace_en = 1'b0;
        check("trace length", 64'(trace_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < trace_q.size(); i++) begin
            int a;
            a = 32766 + i;
            check("trace cs", 64'(trace_q[i].cs), 64'(1 << (a / BANK_WORDS)));
            check("trace addr", 64'(trace_q[i].a), 64'(a % BANK_WORDS));
            check("trace no bubble", 64'(trace_q[i].c - trace_q[0].c), 64'(i));
        end

        // 20 forced mismatches overflow the 16-entry log.
        fill(100, 140, 0);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] o;
            o = 8'($urandom_range(0, 63));
            set_pair(100 + 2 * i, o, o + 8'd5);
        end
        run(100, 140, 2, 0);

        // Extreme signed values: |0x7F - 0x80| = 255, no wrap.
        fill(300, 301, 0);
        set_pair(300, 8'h7F, 8'h80);
        run(300, 301, 1, 0);
        run(300, 301, 255, 0);

        // Empty and inverted ranges.
        run(10, 10, 0, 0);
        run(20, 10, 0, 0);

        // word_end beyond the memory is clamped.
        fill(TOTAL - 8, TOTAL, 0);
        set_pair(TOTAL - 1, 8'h00, 8'hF0);
        run(TOTAL - 8, 262143, 0, 0);

        // Abort mid-sweep: only completed compares count.
        fill(1000, 1050, 0);
        for (int a = 1000; a < 1050; a += 3) set_pair(a, 8'h20, 8'h40);
        run(1000, 1050, 0, 10);

        // Randomised ranges, tolerances and deltas.
        for (int it = 0; it < 8; it++) begin
            int b, len, t;
            b = int'($urandom_range(0, TOTAL - 400));
            len = int'($urandom_range(1, 300));
            t = int'($urandom_range(0, 4));
            fill(b, b + len, int'($urandom_range(0, 6)));
            run(b, b + len, t, 0);
        end

        // Reset in the middle of a 1000-word sweep, then rerun.
        fill(5000, 6000, 1);
        word_begin = ADDR_W'(5000);
        word_end = (ADDR_W+1)'(6000);
        tol = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid-run reset");
        @(negedge clk);
        check_reset_outputs("held reset");
        rst = 1'b1;
        @(negedge clk);
        run(5000, 6000, 0, 0);

        check("cs protocol violations", 64'(cs_err), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
